// File: rtl/frame_receiver.sv
// frame_receiver
//   Receive side of the delay tester. Parses the MAC RX byte stream and keeps
//   only frames addressed to MAC_ADDR (or broadcast when ACCEPT_BCAST=1) that
//   carry ETH_TYPE. From each such frame it pulls the 32-bit sequence number
//   and transmit timestamp, then reports the one-way delay against time_now,
//   which was captured on byte 0. Also keeps good, drop and sequence-error
//   counts.
//
// Ports
//   rx_clk, reset        clock (rising edge), async active-high reset
//   mac_rx_data/dvld     frame bytes (no preamble/SFD, FCS at the tail)
//   mac_rx_goodframe     1-cycle status pulse, frame OK
//   mac_rx_badframe      1-cycle status pulse, frame errored
//   time_now             free-running timestamp shared with the sender
//   rx_res_vld           1-cycle pulse, new rx_res_seq / rx_res_delay
//   rx_res_seq/delay     result of the last accepted frame (held)
//   cnt_good/drop/seq_err  saturating 16-bit statistics
module frame_receiver #(
    parameter logic [47:0] MAC_ADDR     = 48'h004e46324300,
    parameter logic [15:0] ETH_TYPE     = 16'h88B5,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_dvld,
    input  logic        mac_rx_goodframe,
    input  logic        mac_rx_badframe,
    input  logic [31:0] time_now,
    output logic        rx_res_vld,
    output logic [31:0] rx_res_seq,
    output logic [31:0] rx_res_delay,
    output logic [15:0] cnt_good,
    output logic [15:0] cnt_drop,
    output logic [15:0] cnt_seq_err
);

    typedef enum logic [3:0] {
        IDLE, DST, SRC, TYPE, SEQ, TSTAMP, PAYLOAD, WAIT_STAT, IGNORE
    } state_t;

    state_t      state, state_nx;
    logic [4:0]  byte_idx;
    logic        uc_ok, bc_ok;       // dest still matches unicast / broadcast
    logic        short_q, short_nx;  // frame ended inside SEQ/TSTAMP
    logic        dvld_q;
    logic [31:0] seq, tstamp, t_start, exp_seq;
    logic        exp_vld;

    logic        start_frame, do_accept, do_drop, eof_short;
    logic        status, stat_good, dst_hit;
    logic [7:0]  type_byte;

    function automatic logic [7:0] mac_byte(input logic [4:0] i);
        case (i)
            5'd0:    mac_byte = MAC_ADDR[47:40];
            5'd1:    mac_byte = MAC_ADDR[39:32];
            5'd2:    mac_byte = MAC_ADDR[31:24];
            5'd3:    mac_byte = MAC_ADDR[23:16];
            5'd4:    mac_byte = MAC_ADDR[15:8];
            default: mac_byte = MAC_ADDR[7:0];
        endcase
    endfunction

    assign status    = mac_rx_goodframe | mac_rx_badframe;
    // both pulses together count as bad
    assign stat_good = mac_rx_goodframe & ~mac_rx_badframe;
    assign type_byte = byte_idx[0] ? ETH_TYPE[7:0] : ETH_TYPE[15:8];
    assign dst_hit   = (uc_ok && (mac_rx_data == mac_byte(byte_idx))) ||
                       (ACCEPT_BCAST && bc_ok && (mac_rx_data == 8'hFF));

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            short_q <= 1'b0;
            dvld_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            short_q <= short_nx;
            dvld_q  <= mac_rx_dvld;
        end
    end

    always_comb begin
        state_nx    = state;
        short_nx    = short_q;
        start_frame = 1'b0;
        do_accept   = 1'b0;
        do_drop     = 1'b0;
        eof_short   = 1'b0;
        case (state)
            IDLE: begin
                if (mac_rx_dvld) begin
                    start_frame = 1'b1;
                    state_nx    = DST;
                end
            end
            DST: begin
                if (!mac_rx_dvld || !dst_hit) state_nx = IGNORE;
                else if (byte_idx == 5'd5)    state_nx = SRC;
            end
            SRC: begin
                if (!mac_rx_dvld)              state_nx = IGNORE;
                else if (byte_idx == 5'd11)    state_nx = TYPE;
            end
            TYPE: begin
                if (!mac_rx_dvld || mac_rx_data != type_byte) state_nx = IGNORE;
                else if (byte_idx == 5'd13)                   state_nx = SEQ;
            end
            SEQ, TSTAMP, PAYLOAD: begin
                if (!mac_rx_dvld) begin
                    // Frame over. The status pulse may already be present on
                    // this first low cycle, so resolve it here if so.
                    eof_short = (state != PAYLOAD);
                    if (status) begin
                        do_accept = stat_good & ~eof_short;
                        do_drop   = ~(stat_good & ~eof_short);
                        state_nx  = IDLE;
                    end else begin
                        short_nx = eof_short;
                        state_nx = WAIT_STAT;
                    end
                end else if (state == SEQ && byte_idx == 5'd17) begin
                    state_nx = TSTAMP;
                end else if (state == TSTAMP && byte_idx == 5'd21) begin
                    state_nx = PAYLOAD;
                end
            end
            WAIT_STAT: begin
                if (status) begin
                    do_accept = stat_good & ~short_q;
                    do_drop   = ~(stat_good & ~short_q);
                    state_nx  = IDLE;
                end else if (mac_rx_dvld) begin
                    // status never came: count the loss, this byte is byte 0
                    do_drop     = 1'b1;
                    start_frame = 1'b1;
                    state_nx    = DST;
                end
            end
            IGNORE: begin
                // A fresh rise is already byte 0 of the next frame; take it
                // now rather than losing it by bouncing through IDLE.
                if (mac_rx_dvld && !dvld_q) begin
                    start_frame = 1'b1;
                    state_nx    = DST;
                end else if (!mac_rx_dvld && status) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (start_frame) short_nx = 1'b0;
    end

    // byte parsing datapath
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
            uc_ok    <= 1'b0;
            bc_ok    <= 1'b0;
            seq      <= '0;
            tstamp   <= '0;
            t_start  <= '0;
        end else begin
            if (start_frame) begin
                byte_idx <= 5'd1;
                t_start  <= time_now;
                uc_ok    <= (mac_rx_data == MAC_ADDR[47:40]);
                bc_ok    <= ACCEPT_BCAST && (mac_rx_data == 8'hFF);
            end else if (mac_rx_dvld) begin
                // saturate so long payloads never alias back onto header bytes
                if (byte_idx != 5'd31) byte_idx <= byte_idx + 5'd1;
                if (state == DST) begin
                    uc_ok <= uc_ok && (mac_rx_data == mac_byte(byte_idx));
                    bc_ok <= bc_ok && (mac_rx_data == 8'hFF);
                end
                if (state == SEQ)    seq    <= {seq[23:0], mac_rx_data};
                if (state == TSTAMP) tstamp <= {tstamp[23:0], mac_rx_data};
            end
        end
    end

    // results and statistics
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            rx_res_vld   <= 1'b0;
            rx_res_seq   <= '0;
            rx_res_delay <= '0;
            cnt_good     <= '0;
            cnt_drop     <= '0;
            cnt_seq_err  <= '0;
            exp_seq      <= '0;
            exp_vld      <= 1'b0;
        end else begin
            rx_res_vld <= do_accept;
            if (do_accept) begin
                rx_res_seq   <= seq;
                rx_res_delay <= t_start - tstamp;   // modular, survives wrap
                if (cnt_good != 16'hFFFF) cnt_good <= cnt_good + 16'd1;
                if (exp_vld && seq != exp_seq && cnt_seq_err != 16'hFFFF)
                    cnt_seq_err <= cnt_seq_err + 16'd1;
                exp_seq <= seq + 32'd1;
                exp_vld <= 1'b1;
            end
            if (do_drop && cnt_drop != 16'hFFFF) cnt_drop <= cnt_drop + 16'd1;
        end
    end

endmodule

// File: tb/tb_frame_receiver.sv
module tb_frame_receiver;

    localparam logic [47:0] MAC   = 48'h004e46324300;
    localparam logic [47:0] BCAST = 48'hffffffffffff;
    localparam logic [15:0] ETH   = 16'h88B5;

    logic        rx_clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  mac_rx_data = '0;
    logic        mac_rx_dvld = 1'b0;
    logic        mac_rx_goodframe = 1'b0;
    logic        mac_rx_badframe = 1'b0;
    logic [31:0] time_now = '0;
    logic        rx_res_vld;
    logic [31:0] rx_res_seq, rx_res_delay;
    logic [15:0] cnt_good, cnt_drop, cnt_seq_err;

    frame_receiver dut (
        .rx_clk(rx_clk), .reset(reset),
        .mac_rx_data(mac_rx_data), .mac_rx_dvld(mac_rx_dvld),
        .mac_rx_goodframe(mac_rx_goodframe), .mac_rx_badframe(mac_rx_badframe),
        .time_now(time_now),
        .rx_res_vld(rx_res_vld), .rx_res_seq(rx_res_seq), .rx_res_delay(rx_res_delay),
        .cnt_good(cnt_good), .cnt_drop(cnt_drop), .cnt_seq_err(cnt_seq_err)
    );

    always #4 rx_clk = ~rx_clk;

    typedef struct { logic [31:0] seq; logic [31:0] delay; int cyc; } exp_t;
    exp_t sb[$];

    int total = 0;
    int fails = 0;
    int cyc = 0;

    // reference model state
    logic [15:0] m_good = '0, m_drop = '0, m_err = '0;
    logic        m_vld = 1'b0, m_pending = 1'b0;
    logic [31:0] m_next = '0;

    // result monitor: sample 1 time unit after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge rx_clk);
            #1;
            cyc++;
            if (rx_res_vld === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_result got seq=%h delay=%h want none", rx_res_seq, rx_res_delay);
                end else begin
                    e = sb.pop_front();
                    total += 2;
                    if (rx_res_seq !== e.seq) begin
                        fails++;
                        $display("FAIL res_seq got=%h want=%h", rx_res_seq, e.seq);
                    end
                    if (rx_res_delay !== e.delay) begin
                        fails++;
                        $display("FAIL res_delay got=%h want=%h", rx_res_delay, e.delay);
                    end
                    if (cyc != e.cyc) begin
                        fails++;
                        $display("FAIL res_latency got cycle=%0d want cycle=%0d", cyc, e.cyc);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                total++;
                fails++;
                $display("FAIL missing_result got none want seq=%h", sb[0].seq);
                void'(sb.pop_front());
            end
        end
    end

    function automatic logic [175:0] build_hdr(input logic [47:0] dst, input logic [15:0] typ,
                                               input logic [31:0] sq, input logic [31:0] ts);
        build_hdr = {dst, 48'h020000000001, typ, sq, ts};
    endfunction

    task automatic model_reset();
        m_good = '0; m_drop = '0; m_err = '0;
        m_vld = 1'b0; m_pending = 1'b0; m_next = '0;
        sb.delete();
    endtask

    task automatic apply_reset();
        @(negedge rx_clk);
        reset = 1'b1;
        mac_rx_dvld = 1'b0;
        repeat (2) @(negedge rx_clk);
        reset = 1'b0;
        model_reset();
    endtask

    // st: 0 no status, 1 good, 2 bad, 3 both; gap: low cycles before status
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] typ,
                              input logic [31:0] sq, input logic [31:0] ts,
                              input logic [31:0] t0, input int len,
                              input int st, input int gap);
        logic [175:0] hdr;
        logic matched;
        hdr = build_hdr(dst, typ, sq, ts);
        matched = (dst == MAC || dst == BCAST) && typ == ETH && len >= 14;
        if (m_pending) begin
            if (m_drop != 16'hFFFF) m_drop++;
            m_pending = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            @(negedge rx_clk);
            mac_rx_dvld = 1'b1;
            mac_rx_data = (i < 22) ? hdr[175-8*i -: 8] : 8'(i * 7);
            time_now    = t0 + 32'(i);
        end
        @(negedge rx_clk);
        mac_rx_dvld = 1'b0;
        mac_rx_data = '0;
        for (int g = 0; g < gap; g++) @(negedge rx_clk);
        if (st != 0) begin
            mac_rx_goodframe = (st == 1 || st == 3);
            mac_rx_badframe  = (st == 2 || st == 3);
            if (matched) begin
                if (st == 1 && len >= 22) begin
                    sb.push_back('{sq, t0 - ts, cyc + 1});
                    if (m_good != 16'hFFFF) m_good++;
                    if (m_vld && sq != m_next && m_err != 16'hFFFF) m_err++;
                    m_next = sq + 32'd1;
                    m_vld = 1'b1;
                end else if (m_drop != 16'hFFFF) begin
                    m_drop++;
                end
            end
            @(negedge rx_clk);
            mac_rx_goodframe = 1'b0;
            mac_rx_badframe  = 1'b0;
        end else if (matched) begin
            m_pending = 1'b1;
        end
        repeat (2) @(negedge rx_clk);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        total += 6;
        if (rx_res_vld !== 1'b0) begin fails++; $display("FAIL reset_vld got=%b want=0", rx_res_vld); end
        if (rx_res_seq !== 32'd0) begin fails++; $display("FAIL reset_seq got=%h want=0", rx_res_seq); end
        if (rx_res_delay !== 32'd0) begin fails++; $display("FAIL reset_delay got=%h want=0", rx_res_delay); end
        if (cnt_good !== 16'd0) begin fails++; $display("FAIL reset_good got=%0d want=0", cnt_good); end
        if (cnt_drop !== 16'd0) begin fails++; $display("FAIL reset_drop got=%0d want=0", cnt_drop); end
        if (cnt_seq_err !== 16'd0) begin fails++; $display("FAIL reset_err got=%0d want=0", cnt_seq_err); end
        repeat (3) @(negedge rx_clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge rx_clk);
    endtask

    task automatic test_basic();
        send_frame(MAC, ETH, 32'h5, 32'h1000, 32'h1064, 72, 1, 1);
        total += 4;
        if (cnt_good !== 16'd1) begin fails++; $display("FAIL basic_good got=%0d want=1", cnt_good); end
        if (cnt_seq_err !== 16'd0) begin fails++; $display("FAIL basic_err got=%0d want=0", cnt_seq_err); end
        if (cnt_drop !== 16'd0) begin fails++; $display("FAIL basic_drop got=%0d want=0", cnt_drop); end
        if (rx_res_delay !== 32'h64) begin fails++; $display("FAIL basic_delay_hold got=%h want=64", rx_res_delay); end
    endtask

    task automatic test_seq();
        apply_reset();
        send_frame(MAC, ETH, 32'd1, 32'h200, 32'h210, 64, 1, 0);
        send_frame(MAC, ETH, 32'd2, 32'h300, 32'h333, 64, 1, 1);
        send_frame(MAC, ETH, 32'd4, 32'h400, 32'h4ff, 64, 1, 0);
        total += 3;
        if (cnt_good !== 16'd3) begin fails++; $display("FAIL seq_good got=%0d want=3", cnt_good); end
        if (cnt_seq_err !== 16'd1) begin fails++; $display("FAIL seq_err got=%0d want=1", cnt_seq_err); end
        if (rx_res_seq !== 32'd4) begin fails++; $display("FAIL seq_last got=%h want=4", rx_res_seq); end
    endtask

    task automatic test_filter();
        send_frame(48'h001122334455, ETH, 32'd5, 32'h10, 32'h20, 64, 1, 1);
        send_frame(MAC, 16'h0800, 32'd5, 32'h10, 32'h20, 64, 1, 0);
        total += 3;
        if (cnt_good !== 16'd3) begin fails++; $display("FAIL filter_good got=%0d want=3", cnt_good); end
        if (cnt_drop !== 16'd0) begin fails++; $display("FAIL filter_drop got=%0d want=0", cnt_drop); end
        if (cnt_seq_err !== 16'd1) begin fails++; $display("FAIL filter_err got=%0d want=1", cnt_seq_err); end
        send_frame(BCAST, ETH, 32'd5, 32'h10, 32'h25, 64, 1, 0);
        total += 2;
        if (cnt_good !== m_good) begin fails++; $display("FAIL bcast_good got=%0d want=%0d", cnt_good, m_good); end
        if (cnt_seq_err !== m_err) begin fails++; $display("FAIL bcast_err got=%0d want=%0d", cnt_seq_err, m_err); end
    endtask

    task automatic test_drop();
        apply_reset();
        send_frame(MAC, ETH, 32'd9, 32'h10, 32'h20, 64, 2, 2);
        total++;
        if (cnt_drop !== 16'd1) begin fails++; $display("FAIL drop_bad got=%0d want=1", cnt_drop); end
        send_frame(MAC, ETH, 32'd9, 32'h10, 32'h20, 16, 1, 0);
        send_frame(MAC, ETH, 32'd9, 32'h10, 32'h20, 64, 3, 1);
        total += 2;
        if (cnt_drop !== 16'd3) begin fails++; $display("FAIL drop_short_both got=%0d want=3", cnt_drop); end
        if (cnt_good !== 16'd0) begin fails++; $display("FAIL drop_good got=%0d want=0", cnt_good); end
    endtask

    task automatic test_wrap();
        send_frame(MAC, ETH, 32'd20, 32'hFFFFFFF0, 32'h00000010, 60, 1, 1);
        repeat (3) @(negedge rx_clk);
        total += 2;
        if (rx_res_delay !== 32'h20) begin fails++; $display("FAIL wrap_delay got=%h want=20", rx_res_delay); end
        if (cnt_good !== m_good) begin fails++; $display("FAIL wrap_good got=%0d want=%0d", cnt_good, m_good); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send_frame(MAC, ETH, 32'd10, 32'h100, 32'h180, 64, 1, 0);
        send_frame(MAC, ETH, 32'd11, 32'h100, 32'h190, 64, 0, 0);
        send_frame(MAC, ETH, 32'd12, 32'h100, 32'h1a0, 64, 1, 0);
        send_frame(MAC, ETH, 32'd13, 32'h100, 32'h1b0, 22, 1, 0);
        total += 3;
        if (cnt_good !== m_good) begin fails++; $display("FAIL b2b_good got=%0d want=%0d", cnt_good, m_good); end
        if (cnt_drop !== m_drop) begin fails++; $display("FAIL b2b_drop got=%0d want=%0d", cnt_drop, m_drop); end
        if (cnt_seq_err !== m_err) begin fails++; $display("FAIL b2b_err got=%0d want=%0d", cnt_seq_err, m_err); end
    endtask

    task automatic test_reset_mid();
        logic [175:0] hdr;
        send_frame(MAC, ETH, 32'd7, 32'h400, 32'h500, 64, 1, 0);
        hdr = build_hdr(MAC, ETH, 32'd8, 32'h600);
        for (int i = 0; i < 16; i++) begin
            @(negedge rx_clk);
            mac_rx_dvld = 1'b1;
            mac_rx_data = hdr[175-8*i -: 8];
        end
        reset = 1'b1;
        #1;
        total += 6;
        if (rx_res_vld !== 1'b0) begin fails++; $display("FAIL mid_vld got=%b want=0", rx_res_vld); end
        if (rx_res_seq !== 32'd0) begin fails++; $display("FAIL mid_seq got=%h want=0", rx_res_seq); end
        if (rx_res_delay !== 32'd0) begin fails++; $display("FAIL mid_delay got=%h want=0", rx_res_delay); end
        if (cnt_good !== 16'd0) begin fails++; $display("FAIL mid_good got=%0d want=0", cnt_good); end
        if (cnt_drop !== 16'd0) begin fails++; $display("FAIL mid_drop got=%0d want=0", cnt_drop); end
        if (cnt_seq_err !== 16'd0) begin fails++; $display("FAIL mid_err got=%0d want=0", cnt_seq_err); end
        mac_rx_dvld = 1'b0;
        repeat (2) @(negedge rx_clk);
        reset = 1'b0;
        model_reset();
        @(negedge rx_clk);
        send_frame(MAC, ETH, 32'd100, 32'h700, 32'h7a0, 64, 1, 1);
        total += 3;
        if (cnt_good !== 16'd1) begin fails++; $display("FAIL after_good got=%0d want=1", cnt_good); end
        if (cnt_seq_err !== 16'd0) begin fails++; $display("FAIL after_err got=%0d want=0", cnt_seq_err); end
        if (rx_res_seq !== 32'd100) begin fails++; $display("FAIL after_seq got=%h want=64", rx_res_seq); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq();
        test_filter();
        test_drop();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge rx_clk);
        total++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
